// File: rtl/accelerator_buffer_reader.sv
// Streams a (base, length) window of the buffer onto a valid/ready port with wrap at DEPTH.
// First beat 3 cycles after start; 4-entry FIFO absorbs read latency and stalls, reads throttle on fullness.
module accelerator_buffer_reader #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 20,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;
    localparam int         CW       = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [1:0]            state;
    logic                  err_r;
    logic [CW-1:0]         len_r;
    logic [CW-1:0]         issued;
    logic [CW-1:0]         popped;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  pipe1;
    logic                  pipe2;
    logic [DATA_WIDTH-1:0] mem [4];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            occ;

    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [2:0]            committed;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [CW-1:0]         len_clamped;

    // Reads already in the 2-stage read pipeline count against FIFO space so a push never overflows.
    assign committed   = occ + {2'b00, pipe1} + {2'b00, pipe2};
    assign issue       = (state == S_RUN) && (issued < len_r) && (committed < 3'd4);
    assign push        = pipe2;
    assign pop         = m_tvalid && m_tready;
    assign next_addr   = (({1'b0, cur_addr} + 1'b1) == DEPTH_C) ? '0 : cur_addr + 1'b1;
    assign len_clamped = (length > DEPTH_C) ? DEPTH_C : length;

    assign m_tvalid = (occ != 3'd0);
    assign m_tdata  = mem[rd_ptr];
    assign m_tlast  = m_tvalid && (popped == len_r - 1'b1);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_FINISH);
    assign err      = (state == S_FINISH) && err_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            err_r    <= 1'b0;
            len_r    <= '0;
            issued   <= '0;
            popped   <= '0;
            cur_addr <= '0;
            rd_addr  <= '0;
            pipe1    <= 1'b0;
            pipe2    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else begin
            pipe1 <= issue;
            pipe2 <= pipe1;
            if (issue) begin
                rd_addr  <= cur_addr;
                cur_addr <= next_addr;
                issued   <= issued + 1'b1;
            end
            if (push) begin
                mem[wr_ptr] <= rd_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                popped <= popped + 1'b1;
            end
            occ <= occ + {2'b00, push} - {2'b00, pop};

            case (state)
                S_IDLE: begin
                    if (start) begin
                        issued   <= '0;
                        popped   <= '0;
                        cur_addr <= base_addr;
                        len_r    <= len_clamped;
                        if ({1'b0, base_addr} >= DEPTH_C) begin
                            err_r <= 1'b1;
                            state <= S_FINISH;
                        end else if (length == '0) begin
                            state <= S_FINISH;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (pop && m_tlast) state <= S_FINISH;
                end
                S_FINISH: begin
                    err_r <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
